// File: rtl/paa_pkg.sv
// Shared constants and parameter legality checks for the partially
// approximate pipelined adder.
package paa_pkg;

  // Each carry segment covers two sum bits.
  localparam int SEG_W = 2;

  // Operand width must be even and within 4..64.
  function automatic bit paa_width_ok(input int width);
    return ((width % 2) == 0) && (width >= 4) && (width <= 64);
  endfunction

  // Number of approximate low-order segments is limited to 0..WIDTH/2.
  function automatic bit paa_approx_ok(input int width, input int segs);
    return (segs >= 0) && (segs <= (width / 2));
  endfunction

  // The error counter needs at least one bit.
  function automatic bit paa_cnt_ok(input int cnt_w);
    return cnt_w >= 1;
  endfunction

endpackage

// File: rtl/paa_seg2.sv
// One 2-bit adder segment. It always produces both the exact and the
// approximate carry-out; mode selects which one feeds the carry chain.
module paa_seg2
  import paa_pkg::*;
(
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  input  logic             mode,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic             co_exact,
  output logic             co_approx
);

  logic c1;

  // Bit-0 full adder, then bit 1 sum and the two candidate carry-outs.
  always_comb begin
    c1        = ((a[0] ^ b[0]) & ci) | (a[0] & b[0]);
    s[0]      = a[0] ^ b[0] ^ ci;
    s[1]      = a[1] ^ b[1] ^ c1;
    co_exact  = (a[1] & b[1]) | ((a[1] ^ b[1]) & c1);
    co_approx = c1 | (a[1] & b[1]);
    co        = mode ? co_approx : co_exact;
  end

endmodule

// File: rtl/paa_pipe_adder.sv
// Two-stage valid/ready pipelined adder with a partially approximate carry
// chain in the low-order segments. Stage 1 adds the lower segments, stage 2
// adds the upper segments and presents the result. An error flag marks
// results that differ from the exact sum; delivered errors are counted.
module paa_pipe_adder
  import paa_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int APPROX_SEGS = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             cnt_clr
);

  if (!paa_width_ok(WIDTH) || !paa_approx_ok(WIDTH, APPROX_SEGS) || !paa_cnt_ok(CNT_W)) begin : g_param_err
    $error("paa_pipe_adder: illegal WIDTH, APPROX_SEGS or CNT_W");
  end

  // Segments are split evenly between the stages; when the segment count is
  // odd the upper stage takes the extra segment so no segment is cut in two.
  localparam int NSEG    = WIDTH / SEG_W;
  localparam int LO_SEGS = NSEG / 2;
  localparam int LO_W    = LO_SEGS * SEG_W;
  localparam int HI_W    = WIDTH - LO_W;

  // Stage 1 state
  logic             s1_valid_reg;
  logic [LO_W-1:0]  s1_lo_sum_reg;
  logic             s1_mid_c_reg;
  logic [HI_W-1:0]  s1_a_hi_reg;
  logic [HI_W-1:0]  s1_b_hi_reg;
  logic             s1_approx_reg;
  logic             s1_lo_err_reg;

  // Stage 2 (output) state
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_reg;
  logic             cout_reg;
  logic             err_reg;
  logic [CNT_W-1:0] err_cnt_reg;

  // Segment wiring: lower segments see the live operands, upper segments see
  // the stage-1 registered upper halves.
  logic [WIDTH-1:0] seg_a;
  logic [WIDTH-1:0] seg_b;
  logic [WIDTH-1:0] seg_sum;
  logic [NSEG-1:0]  seg_cin;
  logic [NSEG-1:0]  seg_co;
  logic [NSEG-1:0]  seg_co_exact;
  logic [NSEG-1:0]  seg_co_approx;
  logic [NSEG-1:0]  seg_mode;
  logic [NSEG-1:0]  seg_fire;

  logic adv1;
  logic adv2;
  logic lo_fire;
  logic hi_fire;

  assign seg_a = {s1_a_hi_reg, in0[LO_W-1:0]};
  assign seg_b = {s1_b_hi_reg, in1[LO_W-1:0]};

  for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
    localparam bit IS_LO     = (gi < LO_SEGS);
    localparam bit IS_APPROX = (gi < APPROX_SEGS);

    if (gi == 0) begin : g_first
      assign seg_cin[gi] = cin;
    end else if (gi == LO_SEGS) begin : g_mid
      assign seg_cin[gi] = s1_mid_c_reg;
    end else begin : g_chain
      assign seg_cin[gi] = seg_co[gi-1];
    end

    // Mode comes from the live input for stage-1 segments and from the
    // registered copy for stage-2 segments.
    if (IS_APPROX) begin : g_approx
      assign seg_mode[gi] = IS_LO ? approx_en : s1_approx_reg;
    end else begin : g_exact
      assign seg_mode[gi] = 1'b0;
    end

    paa_seg2 u_seg (
      .a         (seg_a[gi*SEG_W +: SEG_W]),
      .b         (seg_b[gi*SEG_W +: SEG_W]),
      .ci        (seg_cin[gi]),
      .mode      (seg_mode[gi]),
      .s         (seg_sum[gi*SEG_W +: SEG_W]),
      .co        (seg_co[gi]),
      .co_exact  (seg_co_exact[gi]),
      .co_approx (seg_co_approx[gi])
    );

    // The approximate carry only ever adds a carry the exact rule would not,
    // so the result deviates from the exact sum iff some active approximate
    // segment's two carries disagree.
    assign seg_fire[gi] = seg_mode[gi] & (seg_co_approx[gi] ^ seg_co_exact[gi]);
  end

  assign lo_fire = |seg_fire[LO_SEGS-1:0];
  assign hi_fire = |seg_fire[NSEG-1:LO_SEGS];

  // Handshake: a stage advances when its register is empty or being drained.
  assign adv2     = !out_valid_reg || out_ready;
  assign adv1     = !s1_valid_reg || adv2;
  assign in_ready = adv1;

  // Stage 1: capture lower-half sum, mid carry and upper operand halves.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_lo_sum_reg <= '0;
      s1_mid_c_reg  <= 1'b0;
      s1_a_hi_reg   <= '0;
      s1_b_hi_reg   <= '0;
      s1_approx_reg <= 1'b0;
      s1_lo_err_reg <= 1'b0;
    end else if (adv1) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_lo_sum_reg <= seg_sum[LO_W-1:0];
        s1_mid_c_reg  <= seg_co[LO_SEGS-1];
        s1_a_hi_reg   <= in0[WIDTH-1:LO_W];
        s1_b_hi_reg   <= in1[WIDTH-1:LO_W];
        s1_approx_reg <= approx_en;
        s1_lo_err_reg <= lo_fire;
      end
    end
  end

  // Stage 2: complete the upper half and hold the result until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      cout_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else if (adv2) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_reg  <= {seg_sum[WIDTH-1:LO_W], s1_lo_sum_reg};
        cout_reg <= seg_co[NSEG-1];
        err_reg  <= s1_lo_err_reg | hi_fire;
      end
    end
  end

  // Saturating count of delivered erroneous results; clear wins.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      err_cnt_reg <= '0;
    end else if (out_valid_reg && out_ready && err_reg && (err_cnt_reg != {CNT_W{1'b1}})) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign cout      = cout_reg;
  assign err       = err_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_paa_pipe_adder.sv
// Directed bench for paa_pipe_adder (WIDTH=16, APPROX_SEGS=2, CNT_W=4).
module tb_paa_pipe_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in0;
  logic [15:0] in1;
  logic        cin;
  logic        approx_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        cout;
  logic        err;
  logic [3:0]  err_cnt;
  logic        cnt_clr;

  int n_vec = 0;
  int n_bad = 0;

  paa_pipe_adder #(.WIDTH(16), .APPROX_SEGS(2), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .cin       (cin),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .cout      (cout),
    .err       (err),
    .err_cnt   (err_cnt),
    .cnt_clr   (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in0 = '0; in1 = '0; cin = 1'b0;
    approx_en = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) step();
    n_vec++;
    if (out_valid !== 1'b0 || out !== 16'h0 || cout !== 1'b0 || err !== 1'b0 || err_cnt !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_state: got valid=%b out=%h cout=%b err=%b cnt=%h, expected 0 0000 0 0 0",
               out_valid, out, cout, err, err_cnt);
    end
    rst = 1'b0;
    step();
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_reset: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [15:0] ta [14] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0005, 16'h1234, 16'hFFFF, 16'h0001,
                             16'hFFF4, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0002, 16'h0010, 16'h0004};
    logic [15:0] tb [14] = '{16'h0001, 16'h0001, 16'h0001, 16'h0005, 16'h0101, 16'h0001, 16'h0000,
                             16'h0004, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0002, 16'h0010, 16'h0004};
    logic        tc [14] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0};
    logic        tm [14] = '{1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
    logic [15:0] eo [14] = '{16'h0006, 16'h0002, 16'h0000, 16'h001E, 16'h1335, 16'h0000, 16'h0006,
                             16'h0008, 16'h0002, 16'hFFFF, 16'hFFFF, 16'h0004, 16'h0020, 16'h0018};
    logic        ec [14] = '{0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0};
    logic        ee [14] = '{1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1};
    logic [3:0]  en [14] = '{1, 1, 1, 2, 2, 2, 3, 4, 4, 4, 4, 4, 4, 5};
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in0 = ta[i]; in1 = tb[i]; cin = tc[i]; approx_en = tm[i]; in_valid = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL basic_ready[%0d]: got %b expected 1", i, in_ready);
      end
      step();
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL basic_latency_early[%0d]: out_valid got %b expected 0", i, out_valid);
      end
      step();
      n_vec++;
      if (out_valid !== 1'b1 || out !== eo[i] || cout !== ec[i] || err !== ee[i]) begin
        n_bad++;
        $display("FAIL basic_result[%0d]: got valid=%b out=%h cout=%b err=%b expected 1 %h %b %b",
                 i, out_valid, out, cout, err, eo[i], ec[i], ee[i]);
      end
      step();
      n_vec++;
      if (out_valid !== 1'b0 || err_cnt !== en[i]) begin
        n_bad++;
        $display("FAIL basic_count[%0d]: got valid=%b cnt=%0d expected 0 %0d", i, out_valid, err_cnt, en[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ba [8] = '{16'h0001, 16'h1111, 16'hFFFF, 16'h0005, 16'h8000, 16'h00FF, 16'hFFF4, 16'hABCD};
    logic [15:0] bb [8] = '{16'h0001, 16'h2222, 16'h0001, 16'h0005, 16'h8000, 16'h0001, 16'h0004, 16'h1234};
    logic        bc [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    logic        bm [8] = '{1, 0, 0, 1, 0, 0, 1, 0};
    logic [15:0] bo [8] = '{16'h0006, 16'h3333, 16'h0000, 16'h001E, 16'h0000, 16'h0101, 16'h0008, 16'hBE01};
    logic        bco [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
    logic        be [8] = '{1, 0, 0, 1, 0, 0, 1, 0};
    int tx = 0;
    int rx = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    while (rx < 8 && cyc < 200) begin
      out_ready = ((cyc % 3) == 0);
      in_valid = (tx < 8);
      if (tx < 8) begin
        in0 = ba[tx]; in1 = bb[tx]; cin = bc[tx]; approx_en = bm[tx];
      end
      #1;
      if (stalled) begin
        n_vec++;
        if (out_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_hold_valid[%0d]: got %b expected 1", rx, out_valid);
        end
      end
      stalled = 1'b0;
      if (out_valid === 1'b1) begin
        n_vec++;
        if (out !== bo[rx] || cout !== bco[rx] || err !== be[rx]) begin
          n_bad++;
          $display("FAIL b2b_result[%0d]: got out=%h cout=%b err=%b expected %h %b %b (ready=%b)",
                   rx, out, cout, err, bo[rx], bco[rx], be[rx], out_ready);
        end
        if (out_ready) rx++;
        else stalled = 1'b1;
      end
      if (in_valid && in_ready === 1'b1) tx++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_vec++;
    if (rx != 8 || tx != 8) begin
      n_bad++;
      $display("FAIL b2b_count: got sent=%0d received=%0d expected 8 8", tx, rx);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0 || err_cnt !== 4'd3) begin
      n_bad++;
      $display("FAIL b2b_tail: got valid=%b cnt=%0d expected 0 3", out_valid, err_cnt);
    end
  endtask

  task automatic send_errs(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      in0 = 16'h0001; in1 = 16'h0001; cin = 1'b0; approx_en = 1'b1; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_saturation();
    logic [3:0] exp_after [2] = '{4'd0, 4'd15};
    for (int pass = 0; pass < 2; pass++) begin
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      send_errs(15);
      n_vec++;
      if (err_cnt !== 4'd15) begin
        n_bad++;
        $display("FAIL sat_preload[%0d]: got %0d expected 15", pass, err_cnt);
      end
      in0 = 16'h0001; in1 = 16'h0001; cin = 1'b0; approx_en = 1'b1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      n_vec++;
      if (out_valid !== 1'b1 || err !== 1'b1) begin
        n_bad++;
        $display("FAIL sat_extra_err[%0d]: got valid=%b err=%b expected 1 1", pass, out_valid, err);
      end
      cnt_clr = (pass == 0);
      step();
      cnt_clr = 1'b0;
      n_vec++;
      if (err_cnt !== exp_after[pass]) begin
        n_bad++;
        $display("FAIL sat_final[%0d]: got %0d expected %0d", pass, err_cnt, exp_after[pass]);
      end
    end
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b0;
    in0 = 16'h0001; in1 = 16'h0001; cin = 1'b0; approx_en = 1'b1; in_valid = 1'b1;
    step();
    in0 = 16'h0005; in1 = 16'h0005;
    step();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out !== 16'h0006) begin
      n_bad++;
      $display("FAIL flight_setup: got valid=%b out=%h expected 1 0006", out_valid, out);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || out !== 16'h0 || err !== 1'b0 || err_cnt !== 4'd0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flight_reset: got valid=%b out=%h err=%b cnt=%0d ready=%b expected 0 0000 0 0 1",
               out_valid, out, err, err_cnt, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL flight_ghost[%0d]: out_valid got %b expected 0", i, out_valid);
      end
    end
    n_vec++;
    if (err_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL flight_count: got %0d expected 0", err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
